// File: rtl/life_grid_engine.sv
`default_nettype none
// ============================================================================
// Module   : life_grid_engine
// Brief    : 8x8 Game-of-Life engine; seeds from a fixed pattern or LFSR, then
//            steps one generation per clock until stopped or a still life.
//            Define LIFE_TORUS_EN for a wrap-around (toroidal) grid.
// Revision : 1.0
// ============================================================================
module life_grid_engine #(
  parameter logic [63:0] SEED_DEFAULT = 64'h0000_0000_0007_0402,
  parameter logic [63:0] LFSR_INIT    = 64'hACE1_2468_1357_BDF9,
  parameter int          GEN_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             randomize,
  output logic [63:0]      seed,
  output logic [63:0]      grid,
  output logic [63:0]      next_grid,
  output logic             running,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  localparam logic [63:0] c_lfsr_init = (LFSR_INIT == 64'h0) ? 64'h1 : LFSR_INIT;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STABLE = 2'd2
  } state_t;

  state_t           r_state;
  logic [63:0]      r_grid;
  logic [63:0]      r_lfsr;
  logic [GEN_W-1:0] r_gen;
  logic [99:0]      w_pad;
  logic [63:0]      w_next;
  logic             w_fb;

  // 10x10 padded copy of the grid: the border ring is either dead or the
  // wrapped opposite edge, so every cell sees eight constant neighbour taps.
  for (genvar pr = 0; pr < 10; pr++) begin : g_pad_r
    for (genvar pc = 0; pc < 10; pc++) begin : g_pad_c
`ifdef LIFE_TORUS_EN
      assign w_pad[pr*10+pc] = r_grid[((pr+7)%8)*8 + ((pc+7)%8)];
`else
      if (pr == 0 || pr == 9 || pc == 0 || pc == 9) begin : g_edge
        assign w_pad[pr*10+pc] = 1'b0;
      end else begin : g_core
        assign w_pad[pr*10+pc] = r_grid[(pr-1)*8 + (pc-1)];
      end
`endif
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      localparam int P = (r+1)*10 + (c+1);
      logic [3:0] w_n;
      assign w_n = {3'b0, w_pad[P-11]} + {3'b0, w_pad[P-10]} + {3'b0, w_pad[P-9]}
                 + {3'b0, w_pad[P-1]}                        + {3'b0, w_pad[P+1]}
                 + {3'b0, w_pad[P+9]}  + {3'b0, w_pad[P+10]} + {3'b0, w_pad[P+11]};
      assign w_next[r*8+c] = (w_n == 4'd3) | (r_grid[r*8+c] & (w_n == 4'd2));
    end
  end

  // Taps 64,63,61,60 of a maximal-length polynomial
  assign w_fb = r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grid  <= '0;
      r_gen   <= '0;
      r_lfsr  <= c_lfsr_init;
    end else begin
      r_lfsr <= {r_lfsr[62:0], w_fb};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_grid  <= seed;
            r_gen   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!start) begin
            r_state <= S_IDLE;
          end else if (w_next != r_grid) begin
            r_grid <= w_next;
            if (r_gen != {GEN_W{1'b1}}) r_gen <= r_gen + 1'b1;
          end else begin
            r_state <= S_STABLE;
          end
        end
        S_STABLE: begin
          if (!start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign seed      = randomize ? r_lfsr : SEED_DEFAULT;
  assign grid      = r_grid;
  assign next_grid = w_next;
  assign running   = (r_state == S_RUN);
  assign stable    = (r_state == S_STABLE);
  assign gen_count = r_gen;

endmodule
`default_nettype wire

// File: tb/tb_life_grid_engine.sv
`default_nettype none
// Bench for life_grid_engine: constant vector tables for fixed patterns plus
// randomized runs against a cell-by-cell Game-of-Life reference model.
module tb_life_grid_engine;

  localparam logic [63:0] SEED_A   = 64'h0000_0000_0007_0402;
  localparam logic [63:0] LINIT    = 64'hACE1_2468_1357_BDF9;
  localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK    = 64'h0000_0000_0018_1800;
  localparam logic [63:0] ROW83    = 64'h0000_0000_0000_0083;
`ifdef LIFE_TORUS_EN
  localparam bit          TORUS    = 1'b1;
  localparam logic [63:0] ROW83_NX = 64'h0100_0000_0000_0101;
`else
  localparam bit          TORUS    = 1'b0;
  localparam logic [63:0] ROW83_NX = 64'h0;
`endif

  logic clk, reset;
  logic start_a, rnd_a, start_b, start_c, start_d;
  logic [63:0] seed_a, grid_a, next_a, seed_b, grid_b, next_b;
  logic [63:0] seed_c, grid_c, next_c, seed_d, grid_d, next_d;
  logic run_a, st_a, run_b, st_b, run_c, st_c, run_d, st_d;
  logic [15:0] gen_a, gen_b, gen_c, gen_d;

  int total = 0;
  int bad   = 0;

  life_grid_engine u_dut (.clk(clk), .reset(reset), .start(start_a), .randomize(rnd_a),
    .seed(seed_a), .grid(grid_a), .next_grid(next_a), .running(run_a), .stable(st_a),
    .gen_count(gen_a));
  life_grid_engine #(.SEED_DEFAULT(BLINK_H)) u_blink (.clk(clk), .reset(reset),
    .start(start_b), .randomize(1'b0), .seed(seed_b), .grid(grid_b), .next_grid(next_b),
    .running(run_b), .stable(st_b), .gen_count(gen_b));
  life_grid_engine #(.SEED_DEFAULT(BLOCK)) u_block (.clk(clk), .reset(reset),
    .start(start_c), .randomize(1'b0), .seed(seed_c), .grid(grid_c), .next_grid(next_c),
    .running(run_c), .stable(st_c), .gen_count(gen_c));
  life_grid_engine #(.SEED_DEFAULT(ROW83)) u_row83 (.clk(clk), .reset(reset),
    .start(start_d), .randomize(1'b0), .seed(seed_d), .grid(grid_d), .next_grid(next_d),
    .running(run_d), .stable(st_d), .gen_count(gen_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for u_dut: 0=idle, 1=run, 2=stable
  int          m_state;
  logic [63:0] m_grid, m_lfsr;
  logic [15:0] m_gen;

  function automatic logic [63:0] life_next(input logic [63:0] g, input bit torus);
    logic [63:0] ng = 64'h0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n = 0;
        int alive = int'((g >> (r*8+c)) & 64'd1);
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (torus) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              continue;
            end
            n += int'((g >> (rr*8+cc)) & 64'd1);
          end
        end
        if (n == 3 || (n == 2 && alive == 1)) ng |= (64'd1 << (r*8+c));
      end
    end
    return ng;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_grid  = 64'h0;
    m_gen   = 16'h0;
    m_lfsr  = LINIT;
  endtask

  task automatic model_edge(input logic st, input logic rd);
    logic [63:0] ng;
    case (m_state)
      0: if (st) begin
           m_grid  = rd ? m_lfsr : SEED_A;
           m_gen   = 16'h0;
           m_state = 1;
         end
      1: if (!st) m_state = 0;
         else begin
           ng = life_next(m_grid, TORUS);
           if (ng != m_grid) begin
             m_grid = ng;
             if (m_gen != 16'hFFFF) m_gen = m_gen + 16'd1;
           end else m_state = 2;
         end
      default: if (!st) m_state = 0;
    endcase
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(start_a, rnd_a);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag);
    chk({tag, " grid"},    grid_a, m_grid);
    chk({tag, " gen"},     64'(gen_a), 64'(m_gen));
    chk({tag, " running"}, 64'(run_a), 64'(m_state == 1));
    chk({tag, " stable"},  64'(st_a), 64'(m_state == 2));
    chk({tag, " next"},    next_a, life_next(m_grid, TORUS));
    chk({tag, " seed"},    seed_a, rnd_a ? m_lfsr : SEED_A);
  endtask

  typedef struct {
    logic        st_b;
    logic [63:0] g_b;
    logic [15:0] n_b;
    logic [1:0]  f_b;   // {running, stable}
    logic        st_c;
    logic [63:0] g_c;
    logic [15:0] n_c;
    logic [1:0]  f_c;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [63:0] l3;
    tbl[0] = '{1'b1, BLINK_H, 16'd0, 2'b10, 1'b1, BLOCK, 16'd0, 2'b10};
    tbl[1] = '{1'b1, BLINK_V, 16'd1, 2'b10, 1'b1, BLOCK, 16'd0, 2'b01};
    tbl[2] = '{1'b1, BLINK_H, 16'd2, 2'b10, 1'b1, BLOCK, 16'd0, 2'b01};
    tbl[3] = '{1'b1, BLINK_V, 16'd3, 2'b10, 1'b0, BLOCK, 16'd0, 2'b00};
    tbl[4] = '{1'b0, BLINK_V, 16'd3, 2'b00, 1'b0, BLOCK, 16'd0, 2'b00};
    tbl[5] = '{1'b1, BLINK_H, 16'd0, 2'b10, 1'b1, BLOCK, 16'd0, 2'b10};

    reset = 1'b0;
    start_a = 0; rnd_a = 0; start_b = 0; start_c = 0; start_d = 0;
    model_reset();
    repeat (2) tick();
    chk("reset grid",    grid_a, 64'h0);
    chk("reset gen",     64'(gen_a), 64'h0);
    chk("reset running", 64'(run_a), 64'h0);
    chk("reset stable",  64'(st_a), 64'h0);
    chk("reset seed",    seed_a, SEED_A);
    chk("reset next",    next_a, 64'h0);
    rnd_a = 1'b1;
    #1 chk("reset lfsr seed", seed_a, LINIT);
    rnd_a = 1'b0;
    @(negedge clk) reset = 1'b1;

    // Glider: load edge, then first generation
    start_a = 1'b1;
    tick();
    chk("glider load grid", grid_a, 64'h0000_0000_0007_0402);
    chk("glider load gen",  64'(gen_a), 64'h0);
    chk_dut("glider load");
    tick();
    chk("glider gen1 grid", grid_a, 64'h0000_0000_0206_0500);
    chk("glider gen1 gen",  64'(gen_a), 64'h1);
    chk("glider gen1 running", 64'(run_a), 64'h1);
    chk_dut("glider gen1");

    for (int i = 0; i < 400; i++) begin
      start_a = ($urandom_range(0, 9) != 0);
      rnd_a   = $urandom_range(0, 1) == 1;
      tick();
      chk_dut("random");
    end
    start_a = 1'b0;
    tick();

    // Row0 = 8'h83: edge behaviour differs between bounded and toroidal grids
    start_d = 1'b1;
    tick();
    chk("row83 grid", grid_d, ROW83);
    chk("row83 next", next_d, ROW83_NX);
    chk("row83 model", next_d, life_next(ROW83, TORUS));
    start_d = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_b = tbl[i].st_b;
      start_c = tbl[i].st_c;
      tick();
      chk($sformatf("blink[%0d] grid", i), grid_b, tbl[i].g_b);
      chk($sformatf("blink[%0d] gen", i), 64'(gen_b), 64'(tbl[i].n_b));
      chk($sformatf("blink[%0d] flags", i), 64'({run_b, st_b}), 64'(tbl[i].f_b));
      chk($sformatf("block[%0d] grid", i), grid_c, tbl[i].g_c);
      chk($sformatf("block[%0d] gen", i), 64'(gen_c), 64'(tbl[i].n_c));
      chk($sformatf("block[%0d] flags", i), 64'({run_c, st_c}), 64'(tbl[i].f_c));
      chk_dut("idle");
    end

    // LFSR seed: load on the edge after three free-running shifts
    @(negedge clk) reset = 1'b0;
    #1 model_reset();
    start_a = 1'b0; rnd_a = 1'b1;
    @(negedge clk) reset = 1'b1;
    repeat (3) tick();
    l3 = LINIT;
    repeat (3) l3 = lfsr_step(l3);
    chk("lfsr3 seed", seed_a, l3);
    start_a = 1'b1;
    tick();
    chk("lfsr3 grid", grid_a, l3);
    chk("lfsr3 nonzero", 64'(grid_a != 64'h0), 64'h1);
    chk_dut("lfsr3");

    // Asynchronous reset between edges while running
    start_a = 1'b0; rnd_a = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    tick();
    chk("prereset running", 64'(run_a), 64'h1);
    chk_dut("prereset");
    tick();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async grid",    grid_a, 64'h0);
    chk("async gen",     64'(gen_a), 64'h0);
    chk("async running", 64'(run_a), 64'h0);
    chk("async stable",  64'(st_a), 64'h0);
    rnd_a = 1'b1;
    @(negedge clk) reset = 1'b1;
    tick();
    chk("reload grid",    grid_a, LINIT);
    chk("reload gen",     64'(gen_a), 64'h0);
    chk("reload running", 64'(run_a), 64'h1);
    chk_dut("reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
8x8 Conway Game-of-Life engine: a 64-bit grid register, a combinational next-generation datapath, and a control FSM that seeds the grid and runs it.
- Seed is either a fixed pattern or a free-running 64-bit LFSR value.
- Sits under the display/top level; the top drives start/randomize and reads grid each cycle.
- Grid mapping: cell (row r, col c) = bit 8r+c; row r = grid[8r+7:8r]; r,c in 0..7.

Parameters:
SEED_DEFAULT, 64'h0000_0000_0007_0402, fixed seed used when randomize=0 (glider: (0,1),(1,2),(2,0),(2,1),(2,2)).
LFSR_INIT, 64'hACE1_2468_1357_BDF9, LFSR reset value; a zero value is replaced by 64'h1.
GEN_W, 16, width of the generation counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  level: 1 = load seed then run; 0 = stop and hold.
randomize  input  1  seed select sampled at load: 1 = LFSR, 0 = SEED_DEFAULT.
seed  output  64  combinational: randomize ? lfsr : SEED_DEFAULT.
grid  output  64  registered current generation.
next_grid  output  64  combinational next generation of grid.
running  output  1  1 in RUN state.
stable  output  1  1 in STABLE state.
gen_count  output  GEN_W  generations computed since last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grid=0, gen_count=0, lfsr=LFSR_INIT.
  - running=0, stable=0.
- LFSR:
  - Fibonacci, taps 64,63,61,60.
  - Shifts left every clock, inserting the XOR of bits 63,62,60,59 at bit 0.
  - Never all-zero.
- Datapath, per cell:
  - n = count of 8 live neighbours; off-grid neighbours read as dead.
  - next = (n==3) | (cell & n==2).
  - Pure combinational; 4-bit counts, no overflow.
- FSM states: IDLE, RUN, STABLE.
  - IDLE, start=1: grid<=seed, gen_count<=0, go RUN. Load takes 1 cycle.
  - IDLE, start=0: hold grid and gen_count.
  - RUN, start=1, next_grid!=grid: grid<=next_grid, gen_count++ (saturates at all-ones), stay RUN.
  - RUN, start=1, next_grid==grid (still life, including all-dead): go STABLE, grid unchanged, gen_count unchanged.
  - RUN or STABLE, start=0: go IDLE, grid held.
  - STABLE, start=1: stay; grid frozen.
- Re-assertion of start from IDLE always reloads a fresh seed; no resume.
- randomize is only sampled on the load edge.
- Asynchronous reset mid-RUN clears immediately; the LFSR restarts from LFSR_INIT.
- Outputs:
  - running = (state==RUN).
  - stable = (state==STABLE).
  - seed and next_grid are valid every cycle, including in IDLE.

Optional Feature:
LIFE_TORUS_EN:
- When defined, neighbour indices wrap modulo 8 in both row and column (toroidal grid).
- When undefined, off-grid neighbours are dead (bounded grid, default).

Test Plan:
- Reset then start=1, randomize=0 → after 1st edge grid=64'h0000_0000_0007_0402; after 2nd edge grid=64'h0000_0000_0206_0500, gen_count=1, running=1.
- SEED_DEFAULT=64'h0000_0000_1C00_0000 (blinker row3 cols2-4), start=1 → grid alternates 64'h0000_0008_0808_0000 / 64'h0000_0000_1C00_0000 each cycle; stable stays 0.
- SEED_DEFAULT=64'h0000_0000_0018_1800 (2x2 block) → 1 load edge, then next edge enters STABLE; grid unchanged, gen_count=0, stable=1. Drop start → IDLE, grid held.
- Row0 = 8'h83, rest 0:
  - Without LIFE_TORUS_EN → next_grid=64'h0.
  - With it → next_grid=64'h0100_0000_0000_0101.
- randomize=1, start asserted on the 3rd clock after reset release → grid equals the LFSR value after 3 shifts from LFSR_INIT; grid is never 0 at load.
- Assert reset low mid-RUN (async, between edges) → grid=0, gen_count=0, state IDLE immediately; start held high → reload on the next edge after reset release.
